gamma_lut_loader: RTL and testbench

- Run-time loader and server for the per-block gamma correction LUT. It replaces a fixed ROM table with a double-buffered 256x8 RAM that can be reloaded.
- Receives a framed 256-entry table over a byte stream, which comes from the config/UART path.
- Validates each table with a checksum and swaps it in only at a frame boundary.
- Serves block-mean lookups with the same 2-cycle latency as the existing gamma stage, so it drops into the block_mean pipeline unchanged.

---
 rtl/gamma_lut_loader.sv | 103 ++++++++++
 tb/tb_gamma_lut_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_lut_loader.sv
// gamma_lut_loader: double-buffered 256x8 gamma LUT, reloaded from a checksummed byte stream and swapped at frame start.
// Optional GAMMA_LUT_READBACK_EN adds a registered shadow-bank readback port (rb_addr_i/rb_data_o).
module gamma_lut_loader #(
    parameter logic [7:0] HDR_BYTE  = 8'hA5,
    parameter int         LUT_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] cfg_data_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic       frame_start_i,
    input  logic [7:0] block_mean_i,
    input  logic       data_valid_i,
`ifdef GAMMA_LUT_READBACK_EN
    input  logic [7:0] rb_addr_i,
    output logic [7:0] rb_data_o,
`endif
    output logic [7:0] block_mean_fixed_o,
    output logic       data_valid_o,
    output logic       lut_valid_o,
    output logic       swap_pending_o,
    output logic       load_err_o
);
    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
    state_t state, state_nx;
    logic [7:0] mem [2*LUT_DEPTH];
    logic [7:0] addr, sum, rd, a1;
    logic       act, acc, wr_en, chk_ok, chk_bad, v1, lv1, sel1;

    assign cfg_ready_o = ~swap_pending_o;
    assign acc = cfg_valid_i & cfg_ready_o;

    always_comb begin
        state_nx = state;
        wr_en    = acc && state == LOAD;
        chk_ok   = acc && state == CHECK && cfg_data_i == sum;
        chk_bad  = acc && state == CHECK && cfg_data_i != sum;
        if (acc)
            state_nx = state == IDLE ? (cfg_data_i == HDR_BYTE ? LOAD : IDLE) :
                       state == LOAD ? (addr == 8'hFF ? CHECK : LOAD) : IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            addr           <= '0;
            sum            <= '0;
            act            <= 1'b0;
            swap_pending_o <= 1'b0;
            lut_valid_o    <= 1'b0;
            load_err_o     <= 1'b0;
        end else begin
            state      <= state_nx;
            addr       <= wr_en ? addr + 8'd1 : (state == IDLE ? 8'd0 : addr);
            sum        <= wr_en ? sum + cfg_data_i : (state == IDLE ? 8'd0 : sum);
            load_err_o <= chk_bad;
            // A pending table blocks the stream, so a swap and a new pass can never coincide.
            if (frame_start_i && swap_pending_o) begin
                act            <= ~act;
                swap_pending_o <= 1'b0;
                lut_valid_o    <= 1'b1;
            end else if (chk_ok) begin
                swap_pending_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{~act, addr}] <= cfg_data_i;
        rd <= mem[{act, block_mean_i}];
    end

    // Bank and lut_valid are captured with the request, so in-flight lookups finish on the old table.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1                 <= 1'b0;
            a1                 <= '0;
            lv1                <= 1'b0;
            sel1               <= 1'b0;
            data_valid_o       <= 1'b0;
            block_mean_fixed_o <= '0;
        end else begin
            v1           <= data_valid_i;
            a1           <= block_mean_i;
            lv1          <= lut_valid_o;
            sel1         <= act;
            data_valid_o <= v1;
            if (v1)
                block_mean_fixed_o <= lv1 ? rd : a1;
        end
    end

`ifdef GAMMA_LUT_READBACK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rb_data_o <= '0;
        else
            rb_data_o <= mem[{~act, rb_addr_i}];
    end
`endif
endmodule

// File: tb/tb_gamma_lut_loader.sv
// tb_gamma_lut_loader: directed self-checking bench for gamma_lut_loader.
// Tables: k0 = 255-i, k1 = i+1, k2 = i^5A; each sums to 8'h80.
module tb_gamma_lut_loader;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] cfg_data_i = '0;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic       frame_start_i = 1'b0;
    logic [7:0] block_mean_i = '0;
    logic       data_valid_i = 1'b0;
    logic [7:0] block_mean_fixed_o;
    logic       data_valid_o, lut_valid_o, swap_pending_o, load_err_o;
`ifdef GAMMA_LUT_READBACK_EN
    logic [7:0] rb_addr_i = '0;
    logic [7:0] rb_data_o;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gamma_lut_loader dut (
        .clk(clk), .rstn(rstn),
        .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .frame_start_i(frame_start_i), .block_mean_i(block_mean_i), .data_valid_i(data_valid_i),
`ifdef GAMMA_LUT_READBACK_EN
        .rb_addr_i(rb_addr_i), .rb_data_o(rb_data_o),
`endif
        .block_mean_fixed_o(block_mean_fixed_o), .data_valid_o(data_valid_o),
        .lut_valid_o(lut_valid_o), .swap_pending_o(swap_pending_o), .load_err_o(load_err_o)
    );

    function automatic logic [7:0] tbl(input int k, input int i);
        logic [7:0] b = 8'(i);
        return k == 0 ? ~b : k == 1 ? b + 8'd1 : b ^ 8'h5A;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        cfg_data_i  = b;
        cfg_valid_i = 1'b1;
        @(negedge clk);
        while (!cfg_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: cfg_ready_o stayed 0, required 1");
        end
        step();
        cfg_valid_i = 1'b0;
    endtask

    task automatic load_table(input int k, input logic [7:0] chk, input bit junk, input int n);
        if (junk) begin
            send(8'h00);
            send(8'h5A);
        end
        send(8'hA5);
        for (int i = 0; i < n; i++) begin
            send(tbl(k, i));
            if (junk && i % 37 == 5) begin
                step();
                step();
            end
        end
        if (n == 256)
            send(chk);
    endtask

    task automatic pulse_fs();
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [7:0] a, input logic [7:0] exp);
        block_mean_i = a;
        data_valid_i = 1'b1;
        step();
        data_valid_i = 1'b0;
        n_cmp++;
        if (data_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL %s_early_valid: got %b want 0", nm, data_valid_o);
        end
        step();
        n_cmp++;
        if (data_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL %s_valid: got %b want 1", nm, data_valid_o);
        end
        n_cmp++;
        if (block_mean_fixed_o !== exp) begin
            n_fail++; $display("FAIL %s_data: got %h want %h", nm, block_mean_fixed_o, exp);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (cfg_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready_o);
        end
        n_cmp++;
        if ({data_valid_o, lut_valid_o, swap_pending_o, load_err_o, block_mean_fixed_o} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b%b%b%b %h want 0000 00", data_valid_o, lut_valid_o,
                     swap_pending_o, load_err_o, block_mean_fixed_o);
        end
    endtask

    task automatic test_identity();
        lookup("identity", 8'h40, 8'h40);
        n_cmp++;
        if (lut_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL identity_lut_valid: got %b want 0", lut_valid_o);
        end
        step();
        n_cmp++;
        if (data_valid_o !== 1'b0 || block_mean_fixed_o !== 8'h40) begin
            n_fail++; $display("FAIL identity_hold: got %b/%h want 0/40", data_valid_o, block_mean_fixed_o);
        end
    endtask

    task automatic test_load_swap();
        load_table(0, 8'h80, 1'b0, 256);
        n_cmp++;
        if (swap_pending_o !== 1'b1 || cfg_ready_o !== 1'b0 || load_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pending: got pend=%b ready=%b err=%b want 1/0/0", swap_pending_o, cfg_ready_o, load_err_o);
        end
        lookup("pre_swap", 8'h10, 8'h10);
        pulse_fs();
        n_cmp++;
        if (lut_valid_o !== 1'b1 || swap_pending_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_state: got lv=%b pend=%b ready=%b want 1/0/1", lut_valid_o, swap_pending_o, cfg_ready_o);
        end
        lookup("swapped_10", 8'h10, 8'hEF);
        lookup("swapped_00", 8'h00, 8'hFF);
        lookup("swapped_ff", 8'hFF, 8'h00);
    endtask

    task automatic test_bad_checksum();
        load_table(1, 8'h81, 1'b0, 256);
        n_cmp++;
        if (load_err_o !== 1'b1 || swap_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL bad_chk_err: got err=%b pend=%b want 1/0", load_err_o, swap_pending_o);
        end
        step();
        n_cmp++;
        if (load_err_o !== 1'b0) begin
            n_fail++; $display("FAIL bad_chk_pulse: got err=%b want 0", load_err_o);
        end
        pulse_fs();
        lookup("bad_chk_old", 8'h10, 8'hEF);
    endtask

    task automatic test_junk_gaps();
        load_table(1, 8'h80, 1'b1, 256);
        n_cmp++;
        if (swap_pending_o !== 1'b1 || load_err_o !== 1'b0) begin
            n_fail++; $display("FAIL junk_pending: got pend=%b err=%b want 1/0", swap_pending_o, load_err_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, exp;
        for (int j = 0; j < 10; j++) begin
            block_mean_i  = 8'(j * 29 + 7);
            data_valid_i  = j < 8;
            frame_start_i = j == 4;
            if (j >= 2) begin
                a   = 8'((j - 2) * 29 + 7);
                exp = j - 2 <= 4 ? ~a : a + 8'd1;
                n_cmp++;
                if (data_valid_o !== 1'b1 || block_mean_fixed_o !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_req%0d: got %b/%h want 1/%h", j - 2, data_valid_o, block_mean_fixed_o, exp);
                end
            end
            step();
        end
        data_valid_i  = 1'b0;
        frame_start_i = 1'b0;
        n_cmp++;
        if (swap_pending_o !== 1'b0 || lut_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_state: got pend=%b lv=%b want 0/1", swap_pending_o, lut_valid_o);
        end
    endtask

    task automatic test_reset_midload();
        load_table(2, 8'h00, 1'b0, 100);
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (cfg_ready_o !== 1'b1 || lut_valid_o !== 1'b0 || swap_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reset: got ready=%b lv=%b pend=%b want 1/0/0", cfg_ready_o, lut_valid_o, swap_pending_o);
        end
        step();
        rstn = 1'b1;
        step();
        load_table(2, 8'h80, 1'b0, 256);
        n_cmp++;
        if (swap_pending_o !== 1'b1 || load_err_o !== 1'b0) begin
            n_fail++; $display("FAIL reload_pending: got pend=%b err=%b want 1/0", swap_pending_o, load_err_o);
        end
`ifdef GAMMA_LUT_READBACK_EN
        rb_addr_i = 8'h05;
        step();
        n_cmp++;
        if (rb_data_o !== 8'h5F) begin
            n_fail++; $display("FAIL readback: got %h want 5f", rb_data_o);
        end
`endif
        lookup("reload_identity", 8'h33, 8'h33);
        pulse_fs();
        lookup("reload_10", 8'h10, 8'h4A);
        lookup("reload_ff", 8'hFF, 8'hA5);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        test_reset();
        test_identity();
        test_load_swap();
        test_bad_checksum();
        test_junk_gaps();
        test_back_to_back();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
